// File: rtl/wdg_pkg.sv
// wdg_pkg: shared state encoding and WDCSR field layout for the watchdog service controller
package wdg_pkg;

    typedef enum logic [2:0] {IDLE, CFG, ARMED, KICK, DISARM, FAULT} state_t;

    localparam int EN_BIT     = 0;
    localparam int WTOCNT_LSB = 4;
    localparam int WTOCNT_W   = 10;

    function automatic logic [31:0] wdcsr_word(logic [WTOCNT_W-1:0] wtocnt, logic en);
        wdcsr_word = '0;
        wdcsr_word[WTOCNT_LSB +: WTOCNT_W] = wtocnt;
        wdcsr_word[EN_BIT] = en;
    endfunction

endpackage

// File: rtl/wb_single_write.sv
// wb_single_write: one pipelined Wishbone write with stall handling and ack timeout
module wb_single_write #(
    parameter int                ADDR_W      = 4,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] ADDR        = '0,
    parameter int                ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              start,
    input  logic [DATA_W-1:0] wdata,
    output logic              cyc,
    output logic              stb,
    output logic              we,
    output logic [ADDR_W-1:0] adr,
    output logic [DATA_W-1:0] dat,
    output logic [3:0]        sel,
    input  logic              stall,
    input  logic              ack,
    input  logic              err,
    output logic              done,
    output logic              fail
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [TW-1:0] tmr;
    logic          taken;

    // a response only counts once the strobe is accepted, possibly in the same cycle
    assign taken = !stb || !stall;
    assign done  = cyc && taken && ack;
    assign fail  = cyc && taken && !ack && (err || (!stb && tmr == TW'(ACK_TIMEOUT - 1)));
    assign we    = cyc;
    assign sel   = {4{cyc}};
    assign adr   = cyc ? ADDR : '0;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cyc <= 1'b0;
            stb <= 1'b0;
            dat <= '0;
            tmr <= '0;
        end else if (done || fail) begin
            cyc <= 1'b0;
            stb <= 1'b0;
        end else if (start && !cyc) begin
            cyc <= 1'b1;
            stb <= 1'b1;
            dat <= wdata;
        end else if (cyc) begin
            if (stb && !stall) stb <= 1'b0;
            tmr <= stb ? '0 : tmr + 1'b1;
        end
    end

endmodule

// File: rtl/wdg_service_ctrl.sv
// wdg_service_ctrl: arms the watchdog and kicks it only while the core shows heartbeat
module wdg_service_ctrl
    import wdg_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 4,
    parameter int WB_DATA_WIDTH = 32,
    parameter int WDCSR_ADDR    = 0,
    parameter int KICK_PERIOD   = 64,
    parameter int ACK_TIMEOUT   = 16,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     i_enable,
    input  logic [9:0]               i_wtocnt,
    input  logic                     i_heartbeat,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [WB_ADDR_WIDTH-1:0] o_wb_adr,
    output logic [WB_DATA_WIDTH-1:0] o_wb_dat,
    output logic [3:0]               o_wb_sel,
    input  logic                     i_wb_stall,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_err,
    output logic                     o_armed,
    output logic                     o_starved,
    output logic                     o_fault,
    output logic [CNT_W-1:0]         o_kick_cnt
);

    state_t             state;
    logic [CNT_W-1:0]   period;
    logic               hb_latch;
    logic               start;
    logic               done;
    logic               fail;

    // write states launch exactly once: the state changes on the same edge the write ends
    assign start = (state == CFG || state == KICK || state == DISARM) && !o_wb_cyc;

    wb_single_write #(
        .ADDR_W     (WB_ADDR_WIDTH),
        .DATA_W     (WB_DATA_WIDTH),
        .ADDR       (WB_ADDR_WIDTH'(WDCSR_ADDR)),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_wr (
        .clk  (clk),
        .res_n(res_n),
        .start(start),
        .wdata(WB_DATA_WIDTH'(wdcsr_word(i_wtocnt, state != DISARM))),
        .cyc  (o_wb_cyc),
        .stb  (o_wb_stb),
        .we   (o_wb_we),
        .adr  (o_wb_adr),
        .dat  (o_wb_dat),
        .sel  (o_wb_sel),
        .stall(i_wb_stall),
        .ack  (i_wb_ack),
        .err  (i_wb_err),
        .done (done),
        .fail (fail)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= IDLE;
            period     <= '0;
            hb_latch   <= 1'b0;
            o_armed    <= 1'b0;
            o_starved  <= 1'b0;
            o_fault    <= 1'b0;
            o_kick_cnt <= '0;
        end else begin
            if (i_heartbeat) hb_latch <= 1'b1;
            if (fail) begin
                state   <= FAULT;
                o_fault <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (i_enable) state <= CFG;
                    CFG, KICK: if (done) begin
                        state   <= i_enable ? ARMED : DISARM;
                        period  <= '0;
                        o_armed <= 1'b1;
                        if (state == CFG) begin
                            hb_latch   <= 1'b0;
                            o_kick_cnt <= '0;
                        end else if (~&o_kick_cnt) begin
                            o_kick_cnt <= o_kick_cnt + 1'b1;
                        end
                    end
                    ARMED: if (!i_enable) begin
                        state <= DISARM;
                    end else if (period == CNT_W'(KICK_PERIOD - 1)) begin
                        period <= '0;
                        // a heartbeat on the expiry cycle still belongs to this period
                        if (hb_latch || i_heartbeat) begin
                            state     <= KICK;
                            hb_latch  <= 1'b0;
                            o_starved <= 1'b0;
                        end else begin
                            o_starved <= 1'b1;
                        end
                    end else begin
                        period <= period + 1'b1;
                    end
                    DISARM: if (done) begin
                        state     <= IDLE;
                        o_armed   <= 1'b0;
                        o_starved <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wdg_service_ctrl.sv
// tb_wdg_service_ctrl: scoreboard bench; expected writes queued by stimulus, popped by a bus monitor
module tb_wdg_service_ctrl;

    logic        clk = 1'b0;
    logic        res_n;
    logic        i_enable = 1'b0;
    logic [9:0]  i_wtocnt = 10'h10;
    logic        i_heartbeat = 1'b0;
    logic        i_wb_stall = 1'b0;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_err = 1'b0;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [3:0]  o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_armed, o_starved, o_fault;
    logic [15:0] o_kick_cnt;

    int          total = 0;
    int          passed = 0;
    int          wr_count = 0;
    int          stall_left = 0;
    int          w;
    int          n;
    bit          ack_on = 1'b1;
    bit          ack_same = 1'b0;
    bit          pending = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    wdg_service_ctrl #(
        .WB_ADDR_WIDTH(4),
        .WB_DATA_WIDTH(32),
        .WDCSR_ADDR   (0),
        .KICK_PERIOD  (64),
        .ACK_TIMEOUT  (16),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .res_n      (res_n),
        .i_enable   (i_enable),
        .i_wtocnt   (i_wtocnt),
        .i_heartbeat(i_heartbeat),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .i_wb_stall (i_wb_stall),
        .i_wb_ack   (i_wb_ack),
        .i_wb_err   (i_wb_err),
        .o_armed    (o_armed),
        .o_starved  (o_starved),
        .o_fault    (o_fault),
        .o_kick_cnt (o_kick_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_hb();
        tick();
        i_heartbeat = 1'b1;
        tick();
        i_heartbeat = 1'b0;
    endtask

    // slave: stalls for stall_left cycles, acks one cycle after acceptance (or same cycle)
    initial forever begin
        @(negedge clk);
        if (!res_n) begin
            i_wb_ack   = 1'b0;
            i_wb_stall = 1'b0;
            pending    = 1'b0;
        end else begin
            i_wb_ack   = pending && ack_on;
            pending    = 1'b0;
            i_wb_stall = o_wb_stb && stall_left > 0;
            if (i_wb_stall) stall_left--;
            if (o_wb_stb && !i_wb_stall) begin
                if (ack_same) i_wb_ack = ack_on;
                else pending = 1'b1;
            end
        end
    end

    // monitor: every strobe about to be accepted must match the next queued write
    initial forever begin
        @(negedge clk);
        #1;
        if (res_n && o_wb_stb && !i_wb_stall) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("wr_queued", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("wr_dat", o_wb_dat, exp_q.pop_front());
                chk("wr_adr", 32'(o_wb_adr), 32'd0);
                chk("wr_we_sel", 32'({o_wb_we, o_wb_sel}), 32'h1f);
            end
        end
    end

    initial begin
        res_n = 1'b1;
        #1 res_n = 1'b0;
        #1;
        chk("rst_cyc", 32'(o_wb_cyc), 0);
        chk("rst_stb", 32'(o_wb_stb), 0);
        chk("rst_armed", 32'(o_armed), 0);
        chk("rst_starved", 32'(o_starved), 0);
        chk("rst_fault", 32'(o_fault), 0);
        chk("rst_kick_cnt", 32'(o_kick_cnt), 0);
        repeat (3) tick();
        res_n = 1'b1;

        // boot with three stall cycles
        stall_left = 3;
        exp_q.push_back(32'h0000_0101);
        i_enable = 1'b1;
        for (int i = 0; i < 50 && !o_wb_stb; i++) tick();
        tick();
        tick();
        chk("stb_held_in_stall", 32'(o_wb_stb), 1);
        for (int i = 0; i < 50 && !o_armed; i++) tick();
        chk("armed_boot", 32'(o_armed), 1);
        chk("kick_cnt_boot", 32'(o_kick_cnt), 0);

        // two heartbeats per period give a kick every period
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(32'h0000_0101);
            repeat (20) tick();
            pulse_hb();
            repeat (20) tick();
            pulse_hb();
            for (int i = 0; i < 200 && o_kick_cnt != 16'(k); i++) tick();
            chk("kick_cnt_run", 32'(o_kick_cnt), 32'(k));
            chk("starved_run", 32'(o_starved), 0);
        end

        // starve for two periods
        w = wr_count;
        repeat (140) tick();
        chk("starved_set", 32'(o_starved), 1);
        chk("kick_cnt_starved", 32'(o_kick_cnt), 5);
        chk("no_wr_starved", 32'(wr_count), 32'(w));
        exp_q.push_back(32'h0000_0101);
        pulse_hb();
        for (int i = 0; i < 200 && o_kick_cnt != 16'd6; i++) tick();
        chk("kick_cnt_recover", 32'(o_kick_cnt), 6);
        chk("starved_cleared", 32'(o_starved), 0);

        // disable while the kick is in flight
        exp_q.push_back(32'h0000_0101);
        exp_q.push_back(32'h0000_0100);
        pulse_hb();
        for (int i = 0; i < 200 && !o_wb_cyc; i++) tick();
        chk("kick_started", 32'(o_wb_cyc), 1);
        i_enable = 1'b0;
        for (int i = 0; i < 100 && o_armed; i++) tick();
        chk("disarmed", 32'(o_armed), 0);
        chk("kick_cnt_disarm", 32'(o_kick_cnt), 7);
        chk("starved_disarm", 32'(o_starved), 0);
        chk("queue_drained_disarm", 32'(exp_q.size()), 0);
        w = wr_count;
        repeat (20) tick();
        chk("idle_no_wr", 32'(wr_count), 32'(w));
        chk("idle_cyc", 32'(o_wb_cyc), 0);

        // re-arm with ack in the acceptance cycle
        ack_same = 1'b1;
        i_wtocnt = 10'h3ff;
        exp_q.push_back(32'h0000_3ff1);
        i_enable = 1'b1;
        for (int i = 0; i < 50 && !o_armed; i++) tick();
        chk("armed_same_cycle_ack", 32'(o_armed), 1);
        chk("kick_cnt_rearm", 32'(o_kick_cnt), 0);
        ack_same = 1'b0;

        // reset during a stalled kick
        stall_left = 10;
        pulse_hb();
        for (int i = 0; i < 200 && !o_wb_cyc; i++) tick();
        tick();
        #1 res_n = 1'b0;
        #1;
        chk("async_rst_cyc", 32'(o_wb_cyc), 0);
        chk("async_rst_stb", 32'(o_wb_stb), 0);
        chk("async_rst_armed", 32'(o_armed), 0);
        stall_left = 0;
        tick();
        tick();
        stall_left = 3;
        exp_q.push_back(32'h0000_3ff1);
        res_n = 1'b1;
        for (int i = 0; i < 20 && !o_wb_cyc; i++) tick();
        i_wtocnt = 10'h001;
        for (int i = 0; i < 50 && !o_armed; i++) tick();
        chk("armed_after_rst", 32'(o_armed), 1);

        // slave never acks
        ack_on = 1'b0;
        exp_q.push_back(32'h0000_0011);
        pulse_hb();
        for (int i = 0; i < 200 && !(o_wb_stb && !i_wb_stall); i++) tick();
        tick();
        n = 0;
        while (o_wb_cyc && n < 100) begin
            tick();
            n++;
        end
        chk("ack_timeout_cycles", 32'(n), 16);
        chk("fault_set", 32'(o_fault), 1);
        w = wr_count;
        pulse_hb();
        pulse_hb();
        repeat (100) tick();
        chk("fault_no_wr", 32'(wr_count), 32'(w));
        chk("fault_cyc", 32'(o_wb_cyc), 0);
        chk("fault_sticky", 32'(o_fault), 1);
        res_n = 1'b0;
        #1;
        chk("fault_rst", 32'(o_fault), 0);
        chk("queue_drained_end", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wdg_service_ctrl.md
Name: wdg_service_ctrl

Overview:
Wishbone (pipelined, with stall) master that sequences the watchdog register block.
- Boot: programs WDCSR with enable plus a timeout count.
- Run: re-writes WDCSR every KICK_PERIOD cycles to kick the watchdog, but only while the core has shown liveness via i_heartbeat since the previous kick.
- Starved core: kicks stop, the watchdog expires and the reset controller recovers the system.
- Placement: between the core-liveness signal and the watchdog's Wishbone slave port.

Parameters:
- WB_ADDR_WIDTH, 4, address bus width.
- WB_DATA_WIDTH, 32, data bus width.
- WDCSR_ADDR, 0, WDCSR word address.
- KICK_PERIOD, 64, cycles between kick attempts (>=2).
- ACK_TIMEOUT, 16, cycles allowed from strobe acceptance to ack/err.
- CNT_W, 16, width of the kick and period counters.

Ports:
- clk  in  1  system clock
- res_n  in  1  asynchronous active-low reset
- i_enable  in  1  level; 1 = watchdog should be armed
- i_wtocnt  in  10  timeout count written to WDCSR[13:4]
- i_heartbeat  in  1  single-cycle liveness pulse from core
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  strobe
- o_wb_we  out  1  write enable (always 1 when stb)
- o_wb_adr  out  WB_ADDR_WIDTH  address (WDCSR_ADDR)
- o_wb_dat  out  WB_DATA_WIDTH  write data
- o_wb_sel  out  4  byte select (4'b1111)
- i_wb_stall  in  1  slave stall
- i_wb_ack  in  1  slave ack
- i_wb_err  in  1  slave error
- o_armed  out  1  WDCSR successfully written with en=1
- o_starved  out  1  kick withheld, no heartbeat this period
- o_fault  out  1  sticky; bus error or ack timeout
- o_kick_cnt  out  CNT_W  successful kicks since arm (saturating)

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; heartbeat latch 0. WB outputs are registered.
- WDCSR write word: {18'b0, wtocnt[9:0], 2'b0, 1'b0, en}. i_wtocnt is sampled on the cycle stb is first raised and held until ack.
- Bus transfer:
  - Raise cyc=stb=1.
  - Stb is accepted at the posedge where stb=1 and stall=0; stb drops the next cycle.
  - cyc stays high until ack or err.
  - Ack in the same cycle as acceptance is legal.
  - Ack timeout counter starts at acceptance. On ACK_TIMEOUT expiry: drop cyc, set o_fault, go to FAULT. i_wb_err behaves the same.
- States:
  - IDLE: i_enable=1 -> CFG (write en=1).
  - CFG: ack -> ARMED; o_armed=1; period counter=0; heartbeat latch=0; o_kick_cnt=0.
  - ARMED, period counter increments each cycle. At KICK_PERIOD-1:
    - latch=1 -> KICK (write en=1, same wtocnt); clear latch; clear o_starved.
    - latch=0 -> stay ARMED; o_starved=1; counter wraps to 0.
  - KICK: ack -> ARMED; o_kick_cnt+1 (saturating at all-ones); counter restarts at 0.
  - ARMED with i_enable=0 -> DISARM (write en=0). Ack -> IDLE; o_armed=0; o_starved=0.
  - FAULT: WB idle. Exit only via res_n.
- Heartbeat latch: set by any i_heartbeat pulse in any state. Heartbeat in the same cycle as the period expiry counts for the current period.
- i_enable dropping during CFG/KICK: the in-flight transfer completes, then DISARM follows (never abort a transfer mid-cycle).
- i_enable rising during DISARM: completes to IDLE, then re-enters CFG next cycle.
- Reset mid-transfer: cyc/stb drop asynchronously. No retry state is kept.

Decomposition:
- Package wdg_pkg holds:
  - state enum (IDLE, CFG, ARMED, KICK, DISARM, FAULT);
  - WDCSR field constants (EN_BIT=0, WTOCNT_LSB=4, WTOCNT_W=10).
- Sub-module wb_single_write, the natural one: issues one write, owns the stb/stall/ack/timeout handshake, and returns done/fail pulses. The top FSM requests writes through it.

Test Plan:
- Boot: res_n high, i_enable=1, i_wtocnt=10'h10, slave stall=1 for 3 cycles -> one write of 32'h0000_0101 to address 0; stb held through stall; o_armed=1 after ack.
- Heartbeat every 20 cycles, KICK_PERIOD=64 -> a kick write every 64 cycles (+handshake); o_kick_cnt reaches 5 after 5 periods; o_starved stays 0.
- Heartbeat stops after the 2nd kick -> no further writes; o_starved=1 from the next period boundary; watchdog o_irq2 fires and the reset controller pulses the system reset.
- Slave never acks (ack tied 0), ACK_TIMEOUT=16 -> cyc drops 16 cycles after acceptance; o_fault=1; no further bus activity until reset.
- i_enable=0 during KICK wait -> KICK completes, then a write of 32'h0000_0100 (en=0); o_armed=0; state IDLE.
- res_n asserted while cyc=1 -> cyc/stb/o_armed go 0 immediately; after release with i_enable=1, a fresh CFG write is issued.
